inst_fetch: RTL

- Instruction-fetch stage directly upstream of the instruction decoder in the 3-stage RV32I pipeline.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words with their PCs in a small FIFO and presents one instruction per cycle to decode under a valid/ready handshake.
- Handles control-flow redirects from execute by discarding in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/inst_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fault state enum is only used when FETCH_ALIGN_CHK_EN is defined.
package fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with flush; head is read straight from storage.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output entry_t                   head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_c;
  logic          pop_c;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_c   = pop_i && !empty_o;
  assign push_c  = push_i && (!full_o || pop_c);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_c && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC owner, credit-limited imem requests, response FIFO to decode.
// Define FETCH_ALIGN_CHK_EN to trap misaligned redirect targets as a faulting NOP.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  logic          halt_c;
  logic          credit_ok_c;
  logic          req_fire_c;
  logic [31:0]   redirect_tgt_c;

`ifdef FETCH_ALIGN_CHK_EN
  fetch_state_e state_q, state_d;
  logic         fault_pend_q, fault_pend_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      fault_pend_q <= fault_pend_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

  // A misaligned target parks fetch; the faulting entry is queued the cycle after the flush.
  always_comb begin
    state_d      = state_q;
    fault_pend_d = 1'b0;
    fault_pc_d   = fault_pc_q;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state_d      = HALT;
        fault_pend_d = 1'b1;
        fault_pc_d   = redirect_pc;
      end else begin
        state_d = FETCH;
      end
    end
  end

  assign halt_c     = (state_q == HALT);
  assign inst_fault = inst_valid && head.fault;
`else
  logic [2:0] unused_c;

  assign halt_c     = 1'b0;
  assign inst_fault = 1'b0;
  assign unused_c   = {head.fault, redirect_pc[1:0]};
`endif

  assign credit_ok_c    = ({1'b0, outst_q} + {1'b0, fifo_count}) < SW'(DEPTH);
  assign imem_req_valid = rst_n && !redirect_valid && !halt_c && credit_ok_c;
  assign imem_req_addr  = pc_q;
  assign req_fire_c     = imem_req_valid && imem_req_ready;
  assign redirect_tgt_c = {redirect_pc[31:2], 2'b00};

  // PC, outstanding/discard bookkeeping and FIFO push selection.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + CW'(req_fire_c) - CW'(imem_rsp_valid);
    discard_d  = discard_q;
    fifo_push  = 1'b0;
    push_entry = '{inst: imem_rsp_data, pc: rsp_pc_q, fault: 1'b0};

    if (req_fire_c) pc_d = pc_q + PC_INC;

    if (imem_rsp_valid) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end else begin
        fifo_push = 1'b1;
        rsp_pc_d  = rsp_pc_q + PC_INC;
      end
    end

`ifdef FETCH_ALIGN_CHK_EN
    if (fault_pend_q) begin
      fifo_push  = 1'b1;
      push_entry = '{inst: NOP_INST, pc: fault_pc_q, fault: 1'b1};
    end
`endif

    // Every response still in flight after this cycle belongs to the old stream.
    if (redirect_valid) begin
      fifo_push = 1'b0;
      pc_d      = redirect_tgt_c;
      rsp_pc_d  = redirect_tgt_c;
      discard_d = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (head)
  );

  assign inst_valid = rst_n && !fifo_empty;
  assign fifo_pop   = inst_valid && inst_ready;
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  // Credits must make overflow impossible.
  always_ff @(posedge clk) begin
    if (rst_n && fifo_push) begin
      assert (!fifo_full || fifo_pop);
    end
  end

endmodule
